bus_cycle_controller: RTL and testbench

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

---
 rtl/bus_cycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_bus_cycle_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: sequences one external memory access over multiplexed
// pins. The address goes out high byte first, then low byte, then comes a DATA
// phase that can be stretched by a fixed wait-state count and by ext_rdy.
// Optional build macro BUS_TIMEOUT_EN: abort a DATA phase stalled too long.
module bus_cycle_controller #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        ext_rdy,
  input  logic [7:0]  pin_data_in,
  output logic [7:0]  pin_addr,
  output logic [7:0]  pin_data_out,
  output logic [7:0]  pin_data_oe,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  wait_cnt;
  logic [7:0]  rdata_q;
  logic        accept;
  logic        data_done;

  // A new request is only taken when no access is in flight.
  assign accept    = req && ((state == S_IDLE) || (state == S_DONE));
  // Normal DATA completion: wait states used up and the bus is ready.
  assign data_done = (state == S_DATA) && ext_rdy && (wait_cnt == 4'd0);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       timeout_hit;
  logic       err_q;

  // The counter holds 254 during the 255th consecutive stalled cycle; the
  // edge that would make it 255 is the one that aborts the access.
  assign timeout_hit = (state == S_DATA) && !ext_rdy && (stall_cnt == 8'd254);

  // Count consecutive stalled DATA cycles; cleared on DATA entry and on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == S_ADDR_LO) begin
      stall_cnt <= '0;
    end else if (state == S_DATA) begin
      if (ext_rdy) begin
        stall_cnt <= '0;
      end else if (stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end
  end

  // Error flag is high only for the DONE cycle that follows an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state selection for the access sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = S_ADDR_HI;
        end
      end
      S_ADDR_HI: state_next = S_ADDR_LO;
      S_ADDR_LO: state_next = S_DATA;
      S_DATA: begin
        if (data_done) begin
          state_next = S_DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = S_DONE;
        end
`endif
      end
      S_DONE: state_next = req ? S_ADDR_HI : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request fields; they stay frozen for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rw_q    <= req_rw;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Wait-state counter: loaded entering DATA, counts down only while ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_ADDR_LO) begin
      wait_cnt <= WAIT_INIT;
    end else if ((state == S_DATA) && ext_rdy && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Read result register; only reads update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (data_done && rw_q) begin
      rdata_q <= pin_data_in;
    end
`ifdef BUS_TIMEOUT_EN
    else if (timeout_hit && rw_q) begin
      rdata_q <= 8'hFF;
    end
`endif
  end

  // Pin drive decoded purely from registered state and latched request.
  always_comb begin
    pin_addr     = '0;
    pin_data_out = '0;
    pin_data_oe  = '0;
    case (state)
      S_ADDR_HI: begin
        pin_addr     = addr_q[15:8];
        pin_data_out = {7'b0, rw_q};
        pin_data_oe  = '1;
      end
      S_ADDR_LO, S_DATA: begin
        pin_addr = addr_q[7:0];
        if (!rw_q) begin
          pin_data_out = wdata_q;
          pin_data_oe  = '1;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy  = (state == S_ADDR_HI) || (state == S_ADDR_LO) || (state == S_DATA);
  assign ack   = (state == S_DONE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller with an expected-completion queue.
// Two instances: WAIT_STATES=0 and WAIT_STATES=3, selected by 'sel'.
`define CHK(tag, obs, exp) \
  begin \
    n_checks++; \
    assert ((obs) === (exp)) else begin \
      n_errors++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_bus_cycle_controller;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ext_rdy;
  logic [7:0]  pin_data_in;

  logic [7:0] a0_addr, a0_dout, a0_oe, a0_rdata;
  logic       a0_busy, a0_ack, a0_err;
  logic [7:0] a3_addr, a3_dout, a3_oe, a3_rdata;
  logic       a3_busy, a3_ack, a3_err;

  logic       sel;
  logic [7:0] pin_addr, pin_data_out, pin_data_oe, rdata;
  logic       busy, ack, err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  bus_cycle_controller #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ext_rdy(ext_rdy), .pin_data_in(pin_data_in),
    .pin_addr(a0_addr), .pin_data_out(a0_dout), .pin_data_oe(a0_oe),
    .busy(a0_busy), .ack(a0_ack), .rdata(a0_rdata), .err(a0_err)
  );

  bus_cycle_controller #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ext_rdy(ext_rdy), .pin_data_in(pin_data_in),
    .pin_addr(a3_addr), .pin_data_out(a3_dout), .pin_data_oe(a3_oe),
    .busy(a3_busy), .ack(a3_ack), .rdata(a3_rdata), .err(a3_err)
  );

  always_comb begin
    pin_addr     = sel ? a3_addr  : a0_addr;
    pin_data_out = sel ? a3_dout  : a0_dout;
    pin_data_oe  = sel ? a3_oe    : a0_oe;
    rdata        = sel ? a3_rdata : a0_rdata;
    busy         = sel ? a3_busy  : a0_busy;
    ack          = sel ? a3_ack   : a0_ack;
    err          = sel ? a3_err   : a0_err;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    `CHK({tag, ".pin_addr"}, pin_addr, 8'h00)
    `CHK({tag, ".pin_data_out"}, pin_data_out, 8'h00)
    `CHK({tag, ".pin_data_oe"}, pin_data_oe, 8'h00)
    `CHK({tag, ".busy"}, busy, 1'b0)
    `CHK({tag, ".ack"}, ack, 1'b0)
    `CHK({tag, ".err"}, err, 1'b0)
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed ack expected no pending access", tag);
    end else begin
      e = sb.pop_front();
      `CHK({tag, ".rdata"}, rdata, e.rdata)
      `CHK({tag, ".err"}, err, e.err)
    end
  endtask

  // Issue one access, scramble request inputs while busy, expect ack after
  // exp_steps edges counted from the edge that samples req.
  task automatic run_txn(input string tag, input logic rw, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rdata,
                         input logic exp_err, input int exp_steps, input int limit);
    exp_t e;
    bit   seen;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    req       = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    seen = 1'b0;
    for (int k = 1; k <= limit && !seen; k++) begin
      step();
      if (k == 1) begin
        `CHK({tag, ".hi_addr"}, pin_addr, addr[15:8])
        `CHK({tag, ".hi_dout"}, pin_data_out, {7'b0, rw})
        `CHK({tag, ".hi_oe"}, pin_data_oe, 8'hFF)
        `CHK({tag, ".hi_busy"}, busy, 1'b1)
        req       = 1'b0;
        req_rw    = ~rw;
        req_addr  = ~addr;
        req_wdata = ~wdata;
      end
      if (k == 2) begin
        `CHK({tag, ".lo_addr"}, pin_addr, addr[7:0])
        `CHK({tag, ".lo_dout"}, pin_data_out, rw ? 8'h00 : wdata)
        `CHK({tag, ".lo_oe"}, pin_data_oe, rw ? 8'h00 : 8'hFF)
      end
      if (ack === 1'b1) begin
        seen = 1'b1;
        `CHK({tag, ".latency"}, k, exp_steps)
        `CHK({tag, ".done_busy"}, busy, 1'b0)
        `CHK({tag, ".done_addr"}, pin_addr, 8'h00)
        pop_and_check(tag);
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s.ack_timeout: observed no ack expected ack within %0d cycles", tag, limit);
      void'(sb.pop_front());
    end
    step();
    `CHK({tag, ".ack_pulse"}, ack, 1'b0)
  endtask

  initial begin
    bit seen;
    int k;
    sel         = 1'b0;
    rst_n       = 1'b1;
    req         = 1'b0;
    req_rw      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    ext_rdy     = 1'b1;
    pin_data_in = '0;

    // Reset state, asynchronous assertion before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_async");
    `CHK("reset_async.rdata", rdata, 8'h00)
    step();
    step();
    #2 rst_n = 1'b1;
    check_idle_outputs("reset_hold");

    // Read, no wait states.
    pin_data_in = 8'h5C;
    run_txn("read0", 1'b1, 16'h12AB, 8'h00, 8'h5C, 1'b0, 4, 20);

    // Write; rdata keeps the earlier read result.
    pin_data_in = 8'h3C;
    run_txn("write0", 1'b0, 16'h0200, 8'hA5, 8'h5C, 1'b0, 4, 20);

    // Back-to-back reads with req held and address changed mid-access.
    pin_data_in = 8'h11;
    begin
      exp_t e;
      e.rdata = 8'h11; e.err = 1'b0; sb.push_back(e);
    end
    req = 1'b1; req_rw = 1'b1; req_addr = 16'h3344;
    step();
    `CHK("b2b.first_hi", pin_addr, 8'h33)
    req_addr = 16'h7788;
    step();
    `CHK("b2b.first_lo", pin_addr, 8'h44)
    step();
    `CHK("b2b.first_data", pin_addr, 8'h44)
    step();
    `CHK("b2b.first_ack", ack, 1'b1)
    pop_and_check("b2b.first");
    pin_data_in = 8'h22;
    begin
      exp_t e;
      e.rdata = 8'h22; e.err = 1'b0; sb.push_back(e);
    end
    step();
    `CHK("b2b.second_hi_busy", busy, 1'b1)
    `CHK("b2b.second_hi_addr", pin_addr, 8'h77)
    `CHK("b2b.second_hi_ack", ack, 1'b0)
    req = 1'b0;
    step();
    `CHK("b2b.second_lo", pin_addr, 8'h88)
    step();
    step();
    `CHK("b2b.second_ack", ack, 1'b1)
    pop_and_check("b2b.second");
    step();
    `CHK("b2b.idle", busy, 1'b0)

    // Reset during DATA of a read aborts it without ack.
    pin_data_in = 8'h66;
    begin
      exp_t e;
      e.rdata = 8'h66; e.err = 1'b0; sb.push_back(e);
    end
    req = 1'b1; req_rw = 1'b1; req_addr = 16'h4455;
    step();
    req = 1'b0;
    step();
    step();
    `CHK("rst_mid.busy_before", busy, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    `CHK("rst_mid.rdata", rdata, 8'h00)
    sb.delete();
    step();
    `CHK("rst_mid.no_ack", ack, 1'b0)
    #2 rst_n = 1'b1;
    run_txn("after_rst", 1'b1, 16'h0102, 8'h00, 8'h66, 1'b0, 4, 20);

    // WAIT_STATES=3 with two stalled DATA cycles.
    sel = 1'b1;
    #2 rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    pin_data_in = 8'h9E;
    begin
      exp_t e;
      e.rdata = 8'h9E; e.err = 1'b0; sb.push_back(e);
    end
    req = 1'b1; req_rw = 1'b1; req_addr = 16'hBEEF;
    step();
    `CHK("ws3.hi_addr", pin_addr, 8'hBE)
    req = 1'b0;
    step();
    step();
    `CHK("ws3.data_entry_addr", pin_addr, 8'hEF)
    ext_rdy = 1'b0;
    k = 3;
    seen = 1'b0;
    while (k < 30 && !seen) begin
      step();
      k++;
      if (k == 5) ext_rdy = 1'b1;
      if (ack === 1'b1) begin
        seen = 1'b1;
        `CHK("ws3.latency", k, 9)
        pop_and_check("ws3");
      end else begin
        `CHK("ws3.data_busy", busy, 1'b1)
        `CHK("ws3.data_addr", pin_addr, 8'hEF)
        `CHK("ws3.data_oe", pin_data_oe, 8'h00)
        `CHK("ws3.data_dout", pin_data_out, 8'h00)
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $error("FAIL ws3.ack_timeout: observed no ack expected ack at cycle 9");
    end

    // Indefinite stall on ext_rdy low.
    sel = 1'b0;
    #2 rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    ext_rdy = 1'b0;
`ifdef BUS_TIMEOUT_EN
    run_txn("timeout", 1'b1, 16'h5A5A, 8'h00, 8'hFF, 1'b1, 258, 400);
`else
    req = 1'b1; req_rw = 1'b1; req_addr = 16'h5A5A;
    step();
    req = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    `CHK("stall.busy", busy, 1'b1)
    `CHK("stall.ack", ack, 1'b0)
    `CHK("stall.err", err, 1'b0)
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
